// File: rtl/cellram_pattern_tester.sv
// ============================================================================
// Module  : cellram_pattern_tester
// Brief   : Fills a window of CellRAM words with a seed-derived pattern, reads it
//           back, then repeats with the inverted pattern and reports the results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cellram_pattern_tester #(
    parameter int          WORDS     = 32,
    parameter logic [15:0] BASE_WORD = 16'h0000,
    parameter logic [15:0] SEED      = 16'hA5C3,
    parameter int          TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [15:0] first_err_idx,
    output logic [23:0] cr__addr,
    output logic [15:0] cr__data_in,
    output logic        cr__read,
    output logic        cr__write,
    input  logic        cr__wait,
    input  logic [15:0] cr__data_out,
    output logic [15:0] ss__value
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WR_WAIT = 3'd2;
    localparam logic [2:0] S_RD      = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [15:0] LAST_IDX    = 16'(WORDS - 1);
    localparam logic [9:0]  TIMEOUT_LIM = 10'(TIMEOUT - 1);
    localparam logic [15:0] NO_ERR      = 16'hFFFF;

    logic [2:0]  state;
    logic [15:0] idx;
    logic        pass_sel;
    logic [9:0]  wait_cnt;

    logic [2:0]  state_nxt;
    logic [15:0] idx_nxt;
    logic        pass_sel_nxt;
    logic [9:0]  wait_cnt_nxt;
    logic [15:0] err_nxt;
    logic [15:0] first_nxt;
    logic        timeout_nxt;
    logic [15:0] expected;
    logic        busy_nxt;

    function automatic logic [15:0] pattern(input logic [15:0] i, input logic inv);
        logic [15:0] p;
        p = i ^ SEED;
        return inv ? ~p : p;
    endfunction

    assign expected = pattern(idx, pass_sel);
    assign ss__value = done ? err_count : {pass_sel, idx[14:0]};

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        pass_sel_nxt = pass_sel;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err_count;
        first_nxt    = first_err_idx;
        timeout_nxt  = timeout;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt    = S_WR;
                    idx_nxt      = 16'd0;
                    pass_sel_nxt = 1'b0;
                    err_nxt      = 16'd0;
                    first_nxt    = NO_ERR;
                    timeout_nxt  = 1'b0;
                end
            end
            S_WR: begin
                state_nxt    = S_WR_WAIT;
                wait_cnt_nxt = 10'd0;
            end
            S_RD: begin
                state_nxt    = S_RD_WAIT;
                wait_cnt_nxt = 10'd0;
            end
            S_WR_WAIT: begin
                if (cr__wait) begin
                    if (wait_cnt == TIMEOUT_LIM) begin
                        state_nxt   = S_DONE;
                        timeout_nxt = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 10'd1;
                    end
                end else if (idx == LAST_IDX) begin
                    idx_nxt   = 16'd0;
                    state_nxt = S_RD;
                end else begin
                    idx_nxt   = idx + 16'd1;
                    state_nxt = S_WR;
                end
            end
            S_RD_WAIT: begin
                if (cr__wait) begin
                    if (wait_cnt == TIMEOUT_LIM) begin
                        state_nxt   = S_DONE;
                        timeout_nxt = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 10'd1;
                    end
                end else begin
                    if (cr__data_out != expected) begin
                        if (err_count != 16'hFFFF) begin
                            err_nxt = err_count + 16'd1;
                        end
                        if (first_err_idx == NO_ERR) begin
                            first_nxt = idx;
                        end
                    end
                    if (idx != LAST_IDX) begin
                        idx_nxt   = idx + 16'd1;
                        state_nxt = S_RD;
                    end else if (!pass_sel) begin
                        idx_nxt      = 16'd0;
                        pass_sel_nxt = 1'b1;
                        state_nxt    = S_WR;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy_nxt = (state_nxt == S_WR) || (state_nxt == S_WR_WAIT) ||
                      (state_nxt == S_RD) || (state_nxt == S_RD_WAIT);

    // Strobes, address and write data are registered on entry to WR/RD so the
    // strobe is high exactly during the WR/RD cycle and data stays put after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= 16'd0;
            pass_sel      <= 1'b0;
            wait_cnt      <= 10'd0;
            err_count     <= 16'd0;
            first_err_idx <= NO_ERR;
            timeout       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            cr__read      <= 1'b0;
            cr__write     <= 1'b0;
            cr__addr      <= 24'd0;
            cr__data_in   <= 16'd0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            pass_sel      <= pass_sel_nxt;
            wait_cnt      <= wait_cnt_nxt;
            err_count     <= err_nxt;
            first_err_idx <= first_nxt;
            timeout       <= timeout_nxt;
            busy          <= busy_nxt;
            done          <= (state_nxt == S_DONE);
            pass          <= (state_nxt == S_DONE) && (err_nxt == 16'd0) && !timeout_nxt;
            cr__write     <= (state_nxt == S_WR);
            cr__read      <= (state_nxt == S_RD);
            if ((state_nxt == S_WR) || (state_nxt == S_RD)) begin
                cr__addr <= {7'b0, BASE_WORD + idx_nxt, 1'b0};
            end
            if (state_nxt == S_WR) begin
                cr__data_in <= pattern(idx_nxt, pass_sel_nxt);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cellram_pattern_tester.sv
// ============================================================================
// Module  : tb_cellram_pattern_tester
// Brief   : Directed bench with a behavioural CellRAM controller model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cellram_pattern_tester;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count, first_err_idx, ss_value;
    logic [23:0] cr_addr;
    logic [15:0] cr_data_in, cr_data_out;
    logic        cr_read, cr_write, cr_wait;

    logic        start2;
    logic        busy2, done2, pass2, timeout2;
    logic [15:0] err2, first2, ss2;
    logic [23:0] addr2;
    logic [15:0] din2;
    logic [15:0] dout2;
    logic        rd2, wr2;
    logic        wait2;

    always #5 clk = ~clk;

    cellram_pattern_tester dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_count(err_count), .first_err_idx(first_err_idx),
        .cr__addr(cr_addr), .cr__data_in(cr_data_in), .cr__read(cr_read),
        .cr__write(cr_write), .cr__wait(cr_wait), .cr__data_out(cr_data_out),
        .ss__value(ss_value)
    );

    cellram_pattern_tester #(.WORDS(1), .BASE_WORD(16'hFFFF)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
        .timeout(timeout2), .err_count(err2), .first_err_idx(first2),
        .cr__addr(addr2), .cr__data_in(din2), .cr__read(rd2),
        .cr__write(wr2), .cr__wait(wait2), .cr__data_out(dout2),
        .ss__value(ss2)
    );

    // Controller model for dut: 32-word memory, optional random stretch,
    // read-data corruption and a stuck-busy fault after N writes.
    logic [15:0] mem [0:31];
    int          wcnt, rcnt, stuck_after;
    logic [4:0]  stretch;
    logic        stuck, model_clr, stretch_en, corrupt_en;
    logic [15:0] w35;

    assign cr_wait = stuck || (stretch != 5'd0);

    always @(posedge clk) begin
        if (model_clr) begin
            wcnt <= 0; rcnt <= 0; stretch <= 5'd0; stuck <= 1'b0; w35 <= 16'd0;
        end else begin
            if (stretch != 5'd0) stretch <= stretch - 5'd1;
            if (cr_write) begin
                mem[cr_addr[5:1]] <= cr_data_in;
                if (wcnt == 35) w35 <= cr_data_in;
                if (stuck_after != 0 && wcnt + 1 == stuck_after) stuck <= 1'b1;
                wcnt <= wcnt + 1;
                if (stretch_en) stretch <= 5'($urandom_range(0, 20));
            end
            if (cr_read) begin
                cr_data_out <= mem[cr_addr[5:1]] ^
                               ((corrupt_en && (rcnt == 5 || rcnt == 41)) ? 16'h0100 : 16'h0000);
                rcnt <= rcnt + 1;
                if (stretch_en) stretch <= 5'($urandom_range(0, 20));
            end
        end
    end

    // Single-word model for dut2; flags any access not at the wrapped address.
    logic [15:0] store2;
    int          w2cnt, r2cnt, bad2;
    logic        clr2;
    assign wait2 = 1'b0;

    always @(posedge clk) begin
        if (clr2) begin
            w2cnt <= 0; r2cnt <= 0; bad2 <= 0;
        end else begin
            if (wr2) begin
                store2 <= din2;
                w2cnt  <= w2cnt + 1;
                if (addr2 != 24'h01FFFE) bad2 <= bad2 + 1;
            end
            if (rd2) begin
                dout2 <= store2;
                r2cnt <= r2cnt + 1;
                if (addr2 != 24'h01FFFE) bad2 <= bad2 + 1;
            end
        end
    end

    // Protocol monitor: no overlapping strobes, no strobe while busy,
    // write data held until the write completes.
    int          viol = 0;
    logic        wr_pend = 1'b0;
    logic [15:0] wr_data;
    always @(negedge clk) begin
        if ((cr_read || cr_write) && cr_wait) viol++;
        if (cr_read && cr_write) viol++;
        if (rst || !busy) begin
            wr_pend = 1'b0;
        end else if (cr_write) begin
            wr_pend = 1'b1;
            wr_data = cr_data_in;
        end else if (wr_pend) begin
            if (cr_data_in != wr_data) viol++;
            if (!cr_wait) wr_pend = 1'b0;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int stuck_cyc;

    task automatic run1(input logic s_en, input logic c_en, input int st_after);
        int n;
        stretch_en  = s_en;
        corrupt_en  = c_en;
        stuck_after = st_after;
        model_clr   = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ack_busy", {31'd0, busy}, 32'd1);
        chk("start_clears_done", {31'd0, done}, 32'd0);
        stuck_cyc = 0;
        n = 0;
        while (!done && n < 20000) begin
            if (stuck && busy) stuck_cyc++;
            @(negedge clk);
            n++;
        end
        chk("run_done", {31'd0, done}, 32'd1);
    endtask

    typedef struct {
        logic        s_en;
        logic        c_en;
        int          st_after;
        logic        e_pass;
        logic        e_to;
        logic [15:0] e_err;
        logic [15:0] e_first;
        int          e_wr;
        int          e_rd;
        logic [15:0] e_w35;
        int          e_stuck;
    } vec_t;

    vec_t vecs [4];

    initial begin
        //          stretch corrupt stuck pass to   err    first     wr  rd  w35       stuck_cyc
        vecs[0] = '{1'b0, 1'b0, 0,  1'b1, 1'b0, 16'd0, 16'hFFFF, 64, 64, 16'h5A3F, 0};
        vecs[1] = '{1'b0, 1'b1, 0,  1'b0, 1'b0, 16'd2, 16'd5,    64, 64, 16'h5A3F, 0};
        vecs[2] = '{1'b1, 1'b0, 0,  1'b1, 1'b0, 16'd0, 16'hFFFF, 64, 64, 16'h5A3F, 0};
        vecs[3] = '{1'b0, 1'b0, 10, 1'b0, 1'b1, 16'd0, 16'hFFFF, 10, 0,  16'h0000, 1023};

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        model_clr = 1'b1; clr2 = 1'b1;
        stretch_en = 1'b0; corrupt_en = 1'b0; stuck_after = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_first", {16'd0, first_err_idx}, 32'h0000FFFF);
        chk("rst_strobes", {30'd0, cr_read, cr_write}, 32'd0);
        chk("rst_addr", {8'd0, cr_addr}, 32'd0);
        chk("rst_ss", {16'd0, ss_value}, 32'd0);
        rst = 1'b0; model_clr = 1'b0; clr2 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run1(vecs[i].s_en, vecs[i].c_en, vecs[i].st_after);
            chk($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].e_pass});
            chk($sformatf("v%0d_timeout", i), {31'd0, timeout}, {31'd0, vecs[i].e_to});
            chk($sformatf("v%0d_err", i), {16'd0, err_count}, {16'd0, vecs[i].e_err});
            chk($sformatf("v%0d_first", i), {16'd0, first_err_idx}, {16'd0, vecs[i].e_first});
            chk($sformatf("v%0d_ss", i), {16'd0, ss_value}, {16'd0, vecs[i].e_err});
            chk($sformatf("v%0d_writes", i), wcnt, vecs[i].e_wr);
            chk($sformatf("v%0d_reads", i), rcnt, vecs[i].e_rd);
            chk($sformatf("v%0d_w35", i), {16'd0, w35}, {16'd0, vecs[i].e_w35});
            chk($sformatf("v%0d_stuck_cycles", i), stuck_cyc, vecs[i].e_stuck);
        end
        chk("protocol_violations", viol, 0);

        // Reset in RD_WAIT of the inverted pass, then a clean rerun.
        stretch_en = 1'b0; corrupt_en = 1'b0; stuck_after = 0;
        model_clr = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!(cr_read && rcnt == 32) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("t5_reach_pass1_read", {31'd0, cr_read}, 32'd1);
        end
        @(negedge clk);
        chk("t5_ss_in_rd_wait", {16'd0, ss_value}, 32'h00008000);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_done_pass", {30'd0, done, pass}, 32'd0);
        chk("t5_rst_strobes", {30'd0, cr_read, cr_write}, 32'd0);
        chk("t5_rst_err_first", {err_count, first_err_idx}, 32'h0000FFFF);
        chk("t5_rst_addr_data", {cr_addr[15:0], cr_data_in}, 32'd0);
        chk("t5_rst_ss", {16'd0, ss_value}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run1(1'b0, 1'b0, 0);
        chk("t5_rerun_pass", {30'd0, pass, timeout}, 32'd2);
        chk("t5_rerun_err", {err_count, first_err_idx}, 32'h0000FFFF);
        chk("t5_rerun_counts", wcnt + rcnt, 128);

        // Single word at BASE_WORD=FFFF; extra start pulses while busy.
        clr2 = 1'b1;
        @(negedge clk);
        clr2   = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        begin
            int n;
            n = 0;
            while (!done2 && n < 100) begin
                start2 = busy2;
                @(negedge clk);
                n++;
            end
        end
        start2 = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_done_pass", {30'd0, done2, pass2}, 32'd3);
        chk("t6_writes", w2cnt, 2);
        chk("t6_reads", r2cnt, 2);
        chk("t6_bad_addr", bad2, 0);
        chk("t6_addr", {8'd0, addr2}, 32'h0001FFFE);
        chk("t6_err_first", {err2, first2}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
